// File: rtl/refill_pkg.sv
// ============================================================================
// Module   : refill_pkg
// Purpose  : Shared types and constants for the cache refill controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package refill_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FILL = 2'd3
    } refill_state_t;

    // Store sizes as encoded on wt_size; SZ_READ is the unused encoding.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_READ = 2'b11;

    function automatic int hw_addr_w(input int byte_addr_w);
        return byte_addr_w - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/refill_wbuf.sv
// ============================================================================
// Module   : refill_wbuf
// Purpose  : One-entry write-through buffer; splits a store into halfword beats.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module refill_wbuf
    import refill_pkg::*;
#(
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wt_en,
    input  logic [ADDR_W-1:0] i_wt_addr,
    input  logic [1:0]        i_wt_size,
    input  logic [31:0]       i_wt_data,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [ADDR_W-2:0] o_addr,
    output logic [15:0]       o_wdata,
    output logic [1:0]        o_wmask,
    output logic              o_last
);

    localparam int c_hw_w = hw_addr_w(ADDR_W);

    logic              r_valid;
    logic              r_beat;
    logic              r_lane;
    logic [1:0]        r_size;
    logic [c_hw_w-1:0] r_addr;
    logic [31:0]       r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_beat  <= 1'b0;
            r_lane  <= 1'b0;
            r_size  <= SZ_BYTE;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (!r_valid) begin
            if (i_wt_en && (i_wt_size != SZ_READ)) begin
                r_valid <= 1'b1;
                r_beat  <= 1'b0;
                r_lane  <= i_wt_addr[0];
                r_size  <= i_wt_size;
                r_data  <= i_wt_data;
                // Misaligned halves/words are forced onto their natural boundary.
                r_addr  <= (i_wt_size == SZ_WORD) ? {i_wt_addr[ADDR_W-1:2], 1'b0}
                                                  : i_wt_addr[ADDR_W-1:1];
            end
        end else if (i_pop) begin
            if (o_last) begin
                r_valid <= 1'b0;
            end else begin
                r_beat <= 1'b1;
            end
        end
    end

    always_comb begin
        o_addr  = r_addr;
        o_wdata = {r_data[7:0], r_data[7:0]};
        o_wmask = r_lane ? 2'b10 : 2'b01;
        o_last  = 1'b1;
        case (r_size)
            SZ_WORD: begin
                o_addr  = {r_addr[c_hw_w-1:1], r_beat};
                o_wdata = r_beat ? r_data[31:16] : r_data[15:0];
                o_wmask = 2'b11;
                o_last  = r_beat;
            end
            SZ_HALF: begin
                o_wdata = r_data[15:0];
                o_wmask = 2'b11;
            end
            default: ;
        endcase
    end

    assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
// ============================================================================
// Module   : cache_refill_ctrl
// Purpose  : Arbitrates L1I/L1D refills and write-through stores onto a
//            16-bit backing RAM. Optional miss counters: REFILL_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_refill_ctrl
    import refill_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int CNT_W  = 16
) (
    input  logic              CLK_CPU,
    input  logic              RST,
    input  logic              icache_miss,
    input  logic [ADDR_W-1:0] icache_miss_addr,
    input  logic              dcache_miss,
    input  logic [ADDR_W-1:0] dcache_miss_addr,
    input  logic              wt_en,
    input  logic [ADDR_W-1:0] wt_addr,
    input  logic [1:0]        wt_size,
    input  logic [31:0]       wt_data,
    output logic              icache_fetch,
    output logic              dcache_fetch,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [31:0]       fill_data,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_wmask,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata
`ifdef REFILL_STATS_EN
    ,
    output logic [CNT_W-1:0]  icache_miss_cnt,
    output logic [CNT_W-1:0]  dcache_miss_cnt
`endif
);

    localparam int c_unused_cnt_w = CNT_W;

    refill_state_t     r_state;
    refill_state_t     w_state_nxt;
    logic              r_we;
    logic              r_sel_d;
    logic              r_half;
    logic [ADDR_W-3:0] r_waddr;
    logic [15:0]       r_lo;
    logic [15:0]       r_hi;

    logic              w_pop;
    logic              w_start_wr;
    logic              w_start_rd;
    logic              w_start_sel_d;
    logic              w_req;
    logic              w_fill;
    logic              w_unused;

    logic              w_wb_valid;
    logic [ADDR_W-2:0] w_wb_addr;
    logic [15:0]       w_wb_wdata;
    logic [1:0]        w_wb_wmask;
    logic              w_wb_last;

    refill_wbuf #(
        .ADDR_W (ADDR_W)
    ) u_wbuf (
        .clk       (CLK_CPU),
        .rst       (RST),
        .i_wt_en   (wt_en),
        .i_wt_addr (wt_addr),
        .i_wt_size (wt_size),
        .i_wt_data (wt_data),
        .i_pop     (w_pop),
        .o_valid   (w_wb_valid),
        .o_addr    (w_wb_addr),
        .o_wdata   (w_wb_wdata),
        .o_wmask   (w_wb_wmask),
        .o_last    (w_wb_last)
    );

    always_ff @(posedge CLK_CPU) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Draining the store buffer first keeps a miss to a just-stored line coherent.
    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_start_wr    = 1'b0;
        w_start_rd    = 1'b0;
        w_start_sel_d = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_wb_valid) begin
                    w_state_nxt = REQ;
                    w_start_wr  = 1'b1;
                end else if (dcache_miss) begin
                    w_state_nxt   = REQ;
                    w_start_rd    = 1'b1;
                    w_start_sel_d = 1'b1;
                end else if (icache_miss) begin
                    w_state_nxt = REQ;
                    w_start_rd  = 1'b1;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    if (r_we) begin
                        w_pop = 1'b1;
                        if (w_wb_last) begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    w_state_nxt = r_half ? FILL : REQ;
                end
            end
            FILL: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_CPU) begin
        if (RST) begin
            r_we    <= 1'b0;
            r_sel_d <= 1'b0;
            r_half  <= 1'b0;
            r_waddr <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
        end else begin
            if (w_start_wr) begin
                r_we <= 1'b1;
            end
            if (w_start_rd) begin
                r_we    <= 1'b0;
                r_sel_d <= w_start_sel_d;
                r_half  <= 1'b0;
                r_waddr <= w_start_sel_d ? dcache_miss_addr[ADDR_W-1:2]
                                         : icache_miss_addr[ADDR_W-1:2];
            end
            if ((r_state == WAIT) && mem_rvalid) begin
                if (r_half) begin
                    r_hi <= mem_rdata;
                end else begin
                    r_lo <= mem_rdata;
                end
                r_half <= ~r_half;
            end
        end
    end

    assign w_req  = (r_state == REQ);
    assign w_fill = (r_state == FILL);

    assign mem_req   = w_req;
    assign mem_we    = w_req & r_we;
    assign mem_addr  = !w_req ? '0 : (r_we ? w_wb_addr : {r_waddr, r_half});
    assign mem_wdata = (w_req & r_we) ? w_wb_wdata : 16'h0000;
    assign mem_wmask = (w_req & r_we) ? w_wb_wmask : 2'b00;

    assign icache_fetch = w_fill & ~r_sel_d;
    assign dcache_fetch = w_fill & r_sel_d;
    assign fill_addr    = w_fill ? {r_waddr, 2'b00} : '0;
    assign fill_data    = w_fill ? {r_hi, r_lo} : 32'h0;

    // A miss stops stalling in its own FILL cycle.
    assign stall = (icache_miss & ~icache_fetch)
                 | (dcache_miss & ~dcache_fetch)
                 | (wt_en & w_wb_valid);

    assign w_unused = ^{icache_miss_addr[1:0], dcache_miss_addr[1:0], c_unused_cnt_w[0]};

`ifdef REFILL_STATS_EN
    always_ff @(posedge CLK_CPU) begin
        if (RST) begin
            icache_miss_cnt <= '0;
            dcache_miss_cnt <= '0;
        end else begin
            if (icache_fetch && (icache_miss_cnt != {CNT_W{1'b1}})) begin
                icache_miss_cnt <= icache_miss_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (dcache_fetch && (dcache_miss_cnt != {CNT_W{1'b1}})) begin
                dcache_miss_cnt <= dcache_miss_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
// ============================================================================
// Module   : tb_cache_refill_ctrl
// Purpose  : Scoreboard bench for cache_refill_ctrl with a 16-bit RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_refill_ctrl;

    logic        CLK_CPU;
    logic        RST;
    logic        icache_miss;
    logic [19:0] icache_miss_addr;
    logic        dcache_miss;
    logic [19:0] dcache_miss_addr;
    logic        wt_en;
    logic [19:0] wt_addr;
    logic [1:0]  wt_size;
    logic [31:0] wt_data;
    logic        icache_fetch;
    logic        dcache_fetch;
    logic [19:0] fill_addr;
    logic [31:0] fill_data;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_wmask;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;

    cache_refill_ctrl #(.ADDR_W(20), .CNT_W(16)) dut (
        .CLK_CPU          (CLK_CPU),
        .RST              (RST),
        .icache_miss      (icache_miss),
        .icache_miss_addr (icache_miss_addr),
        .dcache_miss      (dcache_miss),
        .dcache_miss_addr (dcache_miss_addr),
        .wt_en            (wt_en),
        .wt_addr          (wt_addr),
        .wt_size          (wt_size),
        .wt_data          (wt_data),
        .icache_fetch     (icache_fetch),
        .dcache_fetch     (dcache_fetch),
        .fill_addr        (fill_addr),
        .fill_data        (fill_data),
        .stall            (stall),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_wmask        (mem_wmask),
        .mem_ready        (mem_ready),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata)
    );

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          hold_until = 0;
    int          n_wr = 0;
    int          n_rd = 0;
    int          n_dfill = 0;
    int          n_ifill = 0;
    int          n_stable = 0;
    int          last_fill_cyc = 0;
    logic [63:0] exp_mem[$];
    logic [63:0] exp_fill[$];
    logic [15:0] mem_model [0:1023];

    initial begin
        CLK_CPU = 1'b0;
        forever #5 CLK_CPU = ~CLK_CPU;
    end

    always @(posedge CLK_CPU) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    function automatic logic [63:0] mbeat(input logic we, input logic [18:0] a,
                                          input logic [15:0] d, input logic [1:0] m);
        return {26'b0, we, a, d, m};
    endfunction

    function automatic logic [63:0] mfill(input logic i, input logic d, input logic s,
                                          input logic [19:0] a, input logic [31:0] v);
        return {9'b0, i, d, s, a, v};
    endfunction

    // RAM model: accepts on mem_ready, returns read data the following cycle.
    initial begin : responder
        logic        acc;
        logic        we;
        logic [18:0] a;
        logic [15:0] wd;
        logic [1:0]  wm;
        for (int i = 0; i < 1024; i++) mem_model[i] = 16'h0000;
        mem_model[10'h082] = 16'hBEEF;
        mem_model[10'h083] = 16'hDEAD;
        mem_model[10'h020] = 16'h5678;
        mem_model[10'h021] = 16'h1234;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0000;
        forever begin
            @(negedge CLK_CPU);
            acc = mem_req & mem_ready;
            we  = mem_we;
            a   = mem_addr;
            wd  = mem_wdata;
            wm  = mem_wmask;
            if (acc && we) begin
                if (wm[0]) mem_model[a[9:0]][7:0]  = wd[7:0];
                if (wm[1]) mem_model[a[9:0]][15:8] = wd[15:8];
            end
            @(posedge CLK_CPU);
            #1;
            mem_rvalid = acc & ~we;
            mem_rdata  = (acc && !we) ? mem_model[a[9:0]] : 16'h0000;
            mem_ready  = !(cyc < hold_until);
        end
    end

    initial begin : monitor
        logic [38:0] snap;
        logic [38:0] prev_snap;
        logic        prev_wait;
        logic [63:0] e;
        prev_wait = 1'b0;
        prev_snap = '0;
        forever begin
            @(negedge CLK_CPU);
            snap = {mem_req, mem_we, mem_addr, mem_wdata, mem_wmask};
            if (mem_req && mem_ready) begin
                if (exp_mem.size() == 0) begin
                    check("mem_beat_unexpected", mbeat(mem_we, mem_addr, mem_wdata, mem_wmask), 64'h0);
                end else begin
                    e = exp_mem.pop_front();
                    check("mem_beat", mbeat(mem_we, mem_addr, mem_wdata, mem_wmask), e);
                end
                if (mem_we) n_wr++;
                else n_rd++;
            end
            if (mem_req && !mem_ready && prev_wait) begin
                check("req_stable", {25'b0, snap}, {25'b0, prev_snap});
                n_stable++;
            end
            prev_wait = mem_req & ~mem_ready;
            prev_snap = snap;
            if (icache_fetch || dcache_fetch) begin
                if (exp_fill.size() == 0) begin
                    check("fill_unexpected", mfill(icache_fetch, dcache_fetch, stall, fill_addr, fill_data), 64'h0);
                end else begin
                    e = exp_fill.pop_front();
                    check("fill", mfill(icache_fetch, dcache_fetch, stall, fill_addr, fill_data), e);
                end
                if (dcache_fetch) n_dfill++;
                if (icache_fetch) n_ifill++;
                last_fill_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge CLK_CPU);
        #1;
    endtask

    // L1 behaviour: each miss is withdrawn after its fetch strobe has been seen.
    task automatic await(input int dt, input int it, input int wt, input int budget);
        int n;
        n = 0;
        while ((n_dfill < dt || n_ifill < it || n_wr < wt) && n < budget) begin
            tick();
            if (n_dfill >= dt) dcache_miss = 1'b0;
            if (n_ifill >= it) icache_miss = 1'b0;
            n++;
        end
        if (n_dfill < dt || n_ifill < it || n_wr < wt) begin
            check("await_timeout", 64'(n), 64'(budget + 1));
            dcache_miss = 1'b0;
            icache_miss = 1'b0;
        end
        tick();
    endtask

    task automatic store(input logic [19:0] a, input logic [1:0] sz, input logic [31:0] d);
        wt_en   = 1'b1;
        wt_addr = a;
        wt_size = sz;
        wt_data = d;
        tick();
        wt_en   = 1'b0;
    endtask

    initial begin : stimulus
        int t0;
        int tw;
        int base;
        RST = 1'b1;
        icache_miss = 1'b0; icache_miss_addr = '0;
        dcache_miss = 1'b0; dcache_miss_addr = '0;
        wt_en = 1'b0; wt_addr = '0; wt_size = 2'b00; wt_data = '0;
        repeat (3) tick();
        @(negedge CLK_CPU);
        check("rst_mem_req", 64'(mem_req), 64'h0);
        check("rst_fetch", 64'({icache_fetch, dcache_fetch}), 64'h0);
        check("rst_stall", 64'(stall), 64'h0);
        check("rst_fill_data", 64'(fill_data), 64'h0);
        tick();
        RST = 1'b0;
        tick();

        // basic dcache refill with minimum latency
        exp_mem.push_back(mbeat(1'b0, 19'h00082, 16'h0, 2'b00));
        exp_mem.push_back(mbeat(1'b0, 19'h00083, 16'h0, 2'b00));
        exp_fill.push_back(mfill(1'b0, 1'b1, 1'b0, 20'h00104, 32'hDEADBEEF));
        dcache_miss_addr = 20'h00104;
        dcache_miss = 1'b1;
        t0 = cyc;
        @(negedge CLK_CPU);
        check("stall_on_miss", 64'(stall), 64'h1);
        await(n_dfill + 1, n_ifill, n_wr, 40);
        check("min_latency", 64'(last_fill_cyc - t0), 64'd5);

        // simultaneous misses: dcache wins, stall held through first fill
        exp_mem.push_back(mbeat(1'b0, 19'h00082, 16'h0, 2'b00));
        exp_mem.push_back(mbeat(1'b0, 19'h00083, 16'h0, 2'b00));
        exp_mem.push_back(mbeat(1'b0, 19'h00020, 16'h0, 2'b00));
        exp_mem.push_back(mbeat(1'b0, 19'h00021, 16'h0, 2'b00));
        exp_fill.push_back(mfill(1'b0, 1'b1, 1'b1, 20'h00104, 32'hDEADBEEF));
        exp_fill.push_back(mfill(1'b1, 1'b0, 1'b0, 20'h00040, 32'h12345678));
        dcache_miss_addr = 20'h00104;
        icache_miss_addr = 20'h00040;
        dcache_miss = 1'b1;
        icache_miss = 1'b1;
        await(n_dfill + 1, n_ifill + 1, n_wr, 60);

        // write-through word, byte, misaligned half, low-lane byte
        tw = n_wr + 2;
        exp_mem.push_back(mbeat(1'b1, 19'h00100, 16'h3344, 2'b11));
        exp_mem.push_back(mbeat(1'b1, 19'h00101, 16'h1122, 2'b11));
        store(20'h00200, 2'b10, 32'h11223344);
        await(n_dfill, n_ifill, tw, 30);
        tw = n_wr + 1;
        exp_mem.push_back(mbeat(1'b1, 19'h00101, 16'hABAB, 2'b10));
        store(20'h00203, 2'b00, 32'h000000AB);
        await(n_dfill, n_ifill, tw, 30);
        tw = n_wr + 1;
        exp_mem.push_back(mbeat(1'b1, 19'h00103, 16'hCAFE, 2'b11));
        store(20'h00207, 2'b01, 32'h0000CAFE);
        await(n_dfill, n_ifill, tw, 30);
        tw = n_wr + 1;
        exp_mem.push_back(mbeat(1'b1, 19'h00000, 16'h5A5A, 2'b01));
        store(20'h00000, 2'b00, 32'h0000005A);
        await(n_dfill, n_ifill, tw, 30);

        // illegal size is not captured
        tw = n_wr;
        store(20'h00210, 2'b11, 32'hFFFFFFFF);
        repeat (6) tick();
        check("illegal_size_no_write", 64'(n_wr), 64'(tw));

        // second store while buffer full raises stall and is dropped
        hold_until = cyc + 6;
        tick();
        tw = n_wr + 2;
        exp_mem.push_back(mbeat(1'b1, 19'h00100, 16'h5A5A, 2'b11));
        exp_mem.push_back(mbeat(1'b1, 19'h00101, 16'hA5A5, 2'b11));
        store(20'h00200, 2'b10, 32'hA5A55A5A);
        wt_en   = 1'b1;
        wt_addr = 20'h00204;
        wt_data = 32'hFFFF0000;
        @(negedge CLK_CPU);
        check("stall_wbuf_full", 64'(stall), 64'h1);
        tick();
        wt_en = 1'b0;
        await(n_dfill, n_ifill, tw, 30);
        repeat (4) tick();
        check("dropped_store_no_write", 64'(n_wr), 64'(tw));

        // coherence: store then miss to same line
        tw = n_wr + 2;
        exp_mem.push_back(mbeat(1'b1, 19'h00180, 16'h7788, 2'b11));
        exp_mem.push_back(mbeat(1'b1, 19'h00181, 16'h5566, 2'b11));
        exp_mem.push_back(mbeat(1'b0, 19'h00180, 16'h0, 2'b00));
        exp_mem.push_back(mbeat(1'b0, 19'h00181, 16'h0, 2'b00));
        exp_fill.push_back(mfill(1'b0, 1'b1, 1'b0, 20'h00300, 32'h55667788));
        store(20'h00300, 2'b10, 32'h55667788);
        dcache_miss_addr = 20'h00300;
        dcache_miss = 1'b1;
        await(n_dfill + 1, n_ifill, tw, 40);

        // mem_ready held low: request must be stable
        base = n_stable;
        hold_until = cyc + 5;
        tick();
        exp_mem.push_back(mbeat(1'b0, 19'h00082, 16'h0, 2'b00));
        exp_mem.push_back(mbeat(1'b0, 19'h00083, 16'h0, 2'b00));
        exp_fill.push_back(mfill(1'b0, 1'b1, 1'b0, 20'h00104, 32'hDEADBEEF));
        dcache_miss_addr = 20'h00104;
        dcache_miss = 1'b1;
        await(n_dfill + 1, n_ifill, n_wr, 40);
        check("ready_hold_stable_seen", 64'(n_stable - base >= 2), 64'h1);

        // reset while waiting for read data
        base = n_dfill;
        exp_mem.push_back(mbeat(1'b0, 19'h00082, 16'h0, 2'b00));
        dcache_miss_addr = 20'h00104;
        dcache_miss = 1'b1;
        tick();
        tick();
        RST = 1'b1;
        dcache_miss = 1'b0;
        tick();
        @(negedge CLK_CPU);
        check("rst_wait_mem_req", 64'(mem_req), 64'h0);
        check("rst_wait_fetch", 64'({icache_fetch, dcache_fetch}), 64'h0);
        check("rst_wait_fill_data", 64'(fill_data), 64'h0);
        tick();
        RST = 1'b0;
        repeat (8) tick();
        check("rst_wait_no_fill", 64'(n_dfill), 64'(base));

        repeat (4) tick();
        check("exp_mem_drained", 64'(exp_mem.size()), 64'h0);
        check("exp_fill_drained", 64'(exp_fill.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
